// File: rtl/dircc_send_sched_pkg.sv
// Send scheduler FSM encoding and statistics counter width.
package dircc_send_sched_pkg;

  localparam int STAT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    HANDLE,
    CHECK,
    SEND,
    WRITE
  } sched_state_e;

endpackage

// File: rtl/dircc_types_pkg.sv
// Shared DIRCC data types: per-device state record and network packet.
package dircc_types_pkg;

  typedef struct packed {
    logic [7:0]  rts;
    logic [23:0] data;
  } device_state_t;

  typedef struct packed {
    logic [15:0] dest;
    logic [31:0] payload;
  } packet_data_t;

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Round-robin arbiter; ptr is the first slot searched on the next pick.
module dircc_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic             any,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int j;
    any       = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (accept && any) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dircc_send_scheduler.sv
// Shares one send handler across device slots: read, handle, send, write back.
// Optional DIRCC_SEND_SCHED_STATS_EN adds stat_sent / stat_stall counters.
module dircc_send_scheduler
  import dircc_send_sched_pkg::*;
  import dircc_types_pkg::*;
#(
  parameter int NUM_DEVICES       = 4,
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter logic [ADDRESS_MEM_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDRESS_MEM_WIDTH-1:0] STATE_STRIDE = 1,
  parameter int IDX_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_DEVICES-1:0]       rts_req,
  output logic                         grant_valid,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         mem_rd_en,
  output logic [ADDRESS_MEM_WIDTH-1:0] mem_rd_addr,
  input  device_state_t                mem_rd_data,
  output logic [ADDRESS_MEM_WIDTH-1:0] hdl_address,
  output device_state_t                hdl_state,
  input  packet_data_t                 hdl_packet,
  input  logic                         hdl_packet_valid,
  input  device_state_t                hdl_write_state,
  input  logic                         hdl_write_state_valid,
  output logic                         mem_wr_en,
  output logic [ADDRESS_MEM_WIDTH-1:0] mem_wr_addr,
  output device_state_t                mem_wr_data,
  output packet_data_t                 pkt_out,
  output logic                         pkt_out_valid,
  input  logic                         pkt_out_ready,
  output logic                         busy
`ifdef DIRCC_SEND_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]            stat_sent,
  output logic [STAT_W-1:0]            stat_stall
`endif
);

  sched_state_e state, state_n;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             hdl_ok;
  device_state_t    wb_q;
  logic [ADDRESS_MEM_WIDTH-1:0] slot_addr;

  dircc_rr_arbiter #(
    .N     (NUM_DEVICES),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (rts_req),
    .accept    (state == IDLE),
    .any       (arb_any),
    .grant_idx (arb_idx)
  );

  assign slot_addr = BASE_ADDR
                   + ADDRESS_MEM_WIDTH'(idx_q) * STATE_STRIDE;

  // A handler that raises only one of its valids is treated as idle.
  assign hdl_ok = hdl_packet_valid && hdl_write_state_valid;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arb_any) state_n = READ;
      READ:    state_n = LOAD;
      LOAD:    state_n = HANDLE;
      HANDLE:  state_n = CHECK;
      CHECK:   state_n = hdl_ok ? SEND : IDLE;
      SEND:    if (pkt_out_ready) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx_q       <= '0;
      hdl_state   <= '0;
      hdl_address <= '0;
      pkt_out     <= '0;
      wb_q        <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && arb_any) idx_q <= arb_idx;
      if (state == LOAD) begin
        hdl_state   <= mem_rd_data;
        hdl_address <= slot_addr;
      end
      if (state == CHECK && hdl_ok) begin
        pkt_out <= hdl_packet;
        wb_q    <= hdl_write_state;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign grant_valid   = busy;
  assign grant_idx     = idx_q;
  assign mem_rd_en     = (state == READ);
  assign mem_rd_addr   = mem_rd_en ? slot_addr : '0;
  assign pkt_out_valid = (state == SEND);
  assign mem_wr_en     = (state == WRITE);
  assign mem_wr_addr   = mem_wr_en ? slot_addr : '0;
  assign mem_wr_data   = wb_q;

`ifdef DIRCC_SEND_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else if (state == SEND) begin
      if (pkt_out_ready) stat_sent  <= stat_sent + 1'b1;
      else               stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dircc_send_scheduler.sv
// Directed table-driven bench for dircc_send_scheduler with RAM and handler models.
module tb_dircc_send_scheduler;
  import dircc_types_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    rts_req = '0;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic          mem_rd_en;
  logic [31:0]   mem_rd_addr;
  device_state_t mem_rd_data;
  logic [31:0]   hdl_address;
  device_state_t hdl_state;
  packet_data_t  hdl_packet;
  logic          hdl_packet_valid;
  device_state_t hdl_write_state;
  logic          hdl_write_state_valid;
  logic          mem_wr_en;
  logic [31:0]   mem_wr_addr;
  device_state_t mem_wr_data;
  packet_data_t  pkt_out;
  logic          pkt_out_valid;
  logic          pkt_out_ready = 1'b0;
  logic          busy;
`ifdef DIRCC_SEND_SCHED_STATS_EN
  logic [31:0]   stat_sent;
  logic [31:0]   stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  int exp_sent = 0;
  int exp_stall = 0;
  logic mem_load = 1'b1;
  device_state_t mem [4];

  always #5 clk = ~clk;

  dircc_send_scheduler #(
    .NUM_DEVICES       (4),
    .ADDRESS_MEM_WIDTH (32),
    .BASE_ADDR         (32'h10),
    .STATE_STRIDE      (32'h4)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .rts_req               (rts_req),
    .grant_valid           (grant_valid),
    .grant_idx             (grant_idx),
    .mem_rd_en             (mem_rd_en),
    .mem_rd_addr           (mem_rd_addr),
    .mem_rd_data           (mem_rd_data),
    .hdl_address           (hdl_address),
    .hdl_state             (hdl_state),
    .hdl_packet            (hdl_packet),
    .hdl_packet_valid      (hdl_packet_valid),
    .hdl_write_state       (hdl_write_state),
    .hdl_write_state_valid (hdl_write_state_valid),
    .mem_wr_en             (mem_wr_en),
    .mem_wr_addr           (mem_wr_addr),
    .mem_wr_data           (mem_wr_data),
    .pkt_out               (pkt_out),
    .pkt_out_valid         (pkt_out_valid),
    .pkt_out_ready         (pkt_out_ready),
    .busy                  (busy)
`ifdef DIRCC_SEND_SCHED_STATS_EN
    ,
    .stat_sent             (stat_sent),
    .stat_stall            (stat_stall)
`endif
  );

  function automatic logic [1:0] aidx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'h10) >> 2;
    return d[1:0];
  endfunction

  // State RAM: one-cycle read latency, single write port.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 4; k++)
        mem[k] <= '{rts: 8'(k + 2), data: 24'hA00000 + 24'(k)};
    end else begin
      if (mem_rd_en) mem_rd_data <= mem[aidx(mem_rd_addr)];
      if (mem_wr_en) mem[aidx(mem_wr_addr)] <= mem_wr_data;
    end
  end

  // Registered handler: sends one packet and decrements rts when rts != 0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdl_packet_valid      <= 1'b0;
      hdl_write_state_valid <= 1'b0;
      hdl_packet            <= '0;
      hdl_write_state       <= '0;
    end else begin
      hdl_packet_valid      <= (hdl_state.rts != 8'd0);
      hdl_write_state_valid <= (hdl_state.rts != 8'd0);
      hdl_packet      <= '{dest: hdl_address[15:0],
                           payload: {8'h00, hdl_state.data}};
      hdl_write_state <= '{rts: hdl_state.rts - 8'd1,
                           data: hdl_state.data};
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    int          stall;
    int          gidx;
    logic        pkt;
    logic [31:0] addr;
    logic [7:0]  wr_rts;
    logic [23:0] data;
  } vec_t;

  vec_t vecs [9];

  task automatic run_txn(input vec_t v);
    int t, first_v, vcnt, wr_t;
    logic hs, seen_wr, stable, wr_early;
    packet_data_t p0;
    packet_data_t pexp;
    logic [31:0] wa;
    device_state_t wd;
    first_v = -1; vcnt = 0; wr_t = -1;
    hs = 0; seen_wr = 0; stable = 1; wr_early = 0;
    p0 = '0; wa = '0; wd = '0;
    @(negedge clk);
    rts_req = v.req;
    pkt_out_ready = 1'b0;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("grant_wait", 64'(busy), 64'd1);
    rts_req = '0;
    chk("grant_idx", 64'(grant_idx), 64'(v.gidx));
    chk("grant_valid", 64'(grant_valid), 64'd1);
    chk("rd_en", 64'(mem_rd_en), 64'd1);
    chk("rd_addr", 64'(mem_rd_addr), 64'(v.addr));
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
      if (pkt_out_valid) begin
        if (first_v < 0) begin
          first_v = t;
          p0 = pkt_out;
        end else if (pkt_out !== p0) begin
          stable = 0;
        end
        vcnt++;
        pkt_out_ready = (vcnt > v.stall);
        if (pkt_out_ready) hs = 1;
      end else begin
        pkt_out_ready = 1'b0;
      end
      if (mem_wr_en) begin
        seen_wr = 1;
        wr_t = t;
        wa = mem_wr_addr;
        wd = mem_wr_data;
        if (!hs) wr_early = 1;
      end
    end
    pkt_out_ready = 1'b0;
    chk("idle_wait", 64'(busy), 64'd0);
    chk("pkt_seen", 64'(first_v >= 0), 64'(v.pkt));
    chk("wr_seen", 64'(seen_wr), 64'(v.pkt));
    if (v.pkt) begin
      pexp = '{dest: v.addr[15:0], payload: {8'h00, v.data}};
      chk("latency", 64'(first_v), 64'd4);
      chk("pkt_out", 64'(p0), 64'(pexp));
      chk("pkt_stable", 64'(stable), 64'd1);
      chk("valid_cycles", 64'(vcnt), 64'(v.stall + 1));
      chk("wr_after_hs", 64'(wr_early), 64'd0);
      chk("wr_time", 64'(wr_t), 64'(first_v + vcnt));
      chk("wr_addr", 64'(wa), 64'(v.addr));
      chk("wr_rts", 64'(wd.rts), 64'(v.wr_rts));
      chk("wr_data", 64'(wd.data), 64'(v.data));
      exp_sent++;
      exp_stall += v.stall;
    end
`ifdef DIRCC_SEND_SCHED_STATS_EN
    chk("stat_sent", 64'(stat_sent), 64'(exp_sent));
    chk("stat_stall", 64'(stat_stall), 64'(exp_stall));
`endif
  endtask

  initial begin
    int t;
    logic wr_seen;
    vec_t v;
    vecs[0] = '{4'b0001, 0, 0, 1'b1, 32'h10, 8'd1, 24'hA00000};
    vecs[1] = '{4'b1111, 0, 1, 1'b1, 32'h14, 8'd2, 24'hA00001};
    vecs[2] = '{4'b1111, 0, 2, 1'b1, 32'h18, 8'd3, 24'hA00002};
    vecs[3] = '{4'b1111, 0, 3, 1'b1, 32'h1C, 8'd4, 24'hA00003};
    vecs[4] = '{4'b1111, 0, 0, 1'b1, 32'h10, 8'd0, 24'hA00000};
    vecs[5] = '{4'b1111, 5, 1, 1'b1, 32'h14, 8'd1, 24'hA00001};
    vecs[6] = '{4'b0001, 0, 0, 1'b0, 32'h10, 8'd0, 24'hA00000};
    vecs[7] = '{4'b1000, 2, 3, 1'b1, 32'h1C, 8'd3, 24'hA00003};
    vecs[8] = '{4'b0110, 0, 1, 1'b1, 32'h14, 8'd0, 24'hA00001};

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'({grant_valid, grant_idx}), 64'd0);
    chk("rst_rd", 64'({mem_rd_en, mem_rd_addr}), 64'd0);
    chk("rst_wr", 64'({mem_wr_en, mem_wr_addr}), 64'd0);
    chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
    chk("rst_hdl", 64'({hdl_address, hdl_state}), 64'd0);
    chk("rst_pkt", 64'({pkt_out_valid, pkt_out}), 64'd0);
    mem_load = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Reset while a packet waits in SEND: abandoned, no writeback.
    @(negedge clk);
    rts_req = 4'b0100;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    rts_req = '0;
    chk("rst_txn_grant", 64'(grant_idx), 64'd2);
    t = 0;
    while (!pkt_out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_txn_valid", 64'(pkt_out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 64'(pkt_out_valid), 64'd0);
    chk("async_busy", 64'({busy, grant_valid}), 64'd0);
    wr_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_en) wr_seen = 1'b1;
    end
    chk("rst_no_wr", 64'(wr_seen), 64'd0);
    chk("rst_mem_kept", 64'(mem[2].rts), 64'd3);
    exp_sent = 0;
    exp_stall = 0;
    reset_n = 1'b1;

    // Search restarts at slot 0; slot 0 rts is now 0 so it is spurious.
    v = '{4'b1111, 0, 0, 1'b0, 32'h10, 8'd0, 24'hA00000};
    run_txn(v);
    v = '{4'b1111, 0, 1, 1'b0, 32'h14, 8'd0, 24'hA00001};
    run_txn(v);
    v = '{4'b1111, 0, 2, 1'b1, 32'h18, 8'd2, 24'hA00002};
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
